dmux14_dispatch: RTL and testbench



---
 rtl/dmux14_pkg.sv | 31 +++
 rtl/dmux14_fifo.sv | 85 ++++++++
 rtl/dmux14_dispatch.sv | 142 ++++++++++++++
 tb/tb_dmux14_dispatch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dmux14_pkg.sv
// -----------------------------------------------------------------------------
// dmux14_pkg
// Shared definitions for the 1-to-4 demux request sequencer:
//   - dispatcher FSM state encodings
//   - request entry layout {dest, data} and its width
//   - helper to pack a request into an entry
// -----------------------------------------------------------------------------
package dmux14_pkg;

   // Dispatcher FSM states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_PULSE = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   // One buffered request: 2-bit destination channel plus the bit to strobe
   localparam int unsigned ENTRY_W = 3;

   typedef struct packed {
      logic [1:0] dest;
      logic       data;
   } entry_t;

   function automatic entry_t pack_entry(input logic [1:0] dest, input logic data);
      entry_t e;
      e.dest = dest;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/dmux14_fifo.sv
// -----------------------------------------------------------------------------
// dmux14_fifo
// Synchronous FIFO holding dispatch requests. Pointers are log2(DEPTH) bits and
// wrap naturally; occupancy is kept in a separate up/down counter so a full
// FIFO is distinguishable from an empty one.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; empties the FIFO
//   push   in   write wdata (ignored when full)
//   pop    in   discard head entry (ignored when empty)
//   wdata  in   WIDTH  entry to write
//   rdata  out  WIDTH  head entry (valid when !empty)
//   full   out  occupancy == DEPTH
//   empty  out  occupancy == 0
//   count  out  CW     occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module dmux14_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned WIDTH = 3,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr_q];
   assign count   = count_q;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + AW'(1);
      end
      // simultaneous push and pop leaves occupancy unchanged
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // storage needs no reset: entries are only read once counted in
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/dmux14_dispatch.sv
// -----------------------------------------------------------------------------
// dmux14_dispatch
// Request sequencer in front of a combinational 1-to-4 demux. Requests are
// buffered in a FIFO and issued one at a time as a strobe on din. sel is set
// one cycle before din rises and held one cycle after it falls, so the demux
// never sees sel move while din is high. Each slot is SETUP + PULSE_W + GUARD
// cycles; back-to-back requests chain GUARD -> SETUP without visiting IDLE.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset; drops din immediately and
//                  discards all buffered requests
//   in_valid  in   request present
//   in_ready  out  FIFO can accept (not full)
//   in_dest   in   2   destination channel
//   in_data   in   1   bit to strobe onto the channel
//   sel       out  2   registered demux select
//   din       out  1   registered demux data
//   busy      out  FSM active or requests pending
//   count     out  CW  FIFO occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module dmux14_dispatch
   import dmux14_pkg::*;
#(
   parameter  int unsigned DEPTH   = 4,
   parameter  int unsigned PULSE_W = 1,
   localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_dest,
   input  logic          in_data,
   output logic [1:0]    sel,
   output logic          din,
   output logic          busy,
   output logic [CW-1:0] count
);

   // pulse counter holds PULSE_W-1 down to 0
   localparam int unsigned PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

   logic [1:0]         state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic               din_q, din_d;
   logic               data_q, data_d;
   logic [PCW-1:0]     cnt_q, cnt_d;

   logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
   entry_t             head;

   assign in_ready   = !fifo_full;
   assign fifo_push  = in_valid && in_ready;
   assign fifo_wdata = pack_entry(in_dest, in_data);
   assign head       = fifo_rdata;

   dmux14_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      din_d    = din_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sel_d    = head.dest;
               data_d   = head.data;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            // sel has been stable for a full cycle; raise din (stays 0 for data=0)
            din_d   = data_q;
            cnt_d   = PCW'(PULSE_W - 1);
            state_d = ST_PULSE;
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               din_d   = 1'b0;
               state_d = ST_GUARD;
            end else begin
               cnt_d = cnt_q - PCW'(1);
            end
         end
         ST_GUARD: begin
            // din has been low for a cycle, so sel may now move
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sel_d    = head.dest;
               data_d   = head.data;
               state_d  = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            din_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= 2'd0;
         din_q   <= 1'b0;
         data_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         din_q   <= din_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sel  = sel_q;
   assign din  = din_q;
   assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_dmux14_dispatch.sv
module tb_dmux14_dispatch;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 3;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_dest = 2'd0;
   logic          in_data = 1'b0;
   logic [1:0]    sel;
   logic          din;
   logic          busy;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   dmux14_dispatch #(
      .DEPTH   (DEPTH),
      .PULSE_W (PW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_dest  (in_dest),
      .in_data  (in_data),
      .sel      (sel),
      .din      (din),
      .busy     (busy),
      .count    (count)
   );

   // Reference model: each accepted request owns a slot of PW+2 cycles that
   // starts (sel loaded) at edge s = max(prev_s + PW + 2, push_edge + 1).
   // Within a slot: sel = dest from edge s; din = data after edges s+1..s+PW.
   typedef struct {
      int         p;
      int         s;
      logic [1:0] d;
      logic       b;
   } slot_t;

   slot_t      exp_q[$];
   slot_t      cur;
   bit         have_cur;
   int         n_push, n_start, last_start, cyc;
   logic [1:0] last_sel;
   bit         chk_en = 1'b0;
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      have_cur   = 1'b0;
      n_push     = 0;
      n_start    = 0;
      last_start = -1000;
      last_sel   = 2'd0;
      cyc        = 0;
   endtask

   // Offer one request for one clock edge; acc reports whether it was taken.
   task automatic step(input logic v, input logic [1:0] d, input logic b, output bit acc);
      bit rdy;
      in_valid = v;
      in_dest  = d;
      in_data  = b;
      @(posedge clk);
      rdy = (n_push - n_start) != int'(DEPTH);
      cyc++;
      acc = v && rdy;
      if (acc) begin
         slot_t e;
         e.p = cyc;
         e.s = (last_start + int'(PW) + 2 > cyc + 1) ? last_start + int'(PW) + 2 : cyc + 1;
         e.d = d;
         e.b = b;
         last_start = e.s;
         exp_q.push_back(e);
         n_push++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, acc);
   endtask

   // Monitor: at each falling edge retire slots whose start edge has been
   // reached and compare every output against the model.
   int   m_cnt;
   logic m_din;
   always @(negedge clk) begin
      if (chk_en) begin
         while (exp_q.size() > 0 && exp_q[0].s <= cyc) begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
            n_start++;
            last_sel = cur.d;
         end
         if (have_cur && cyc > cur.s + int'(PW) + 1) have_cur = 1'b0;
         m_din = have_cur && cur.b && (cyc >= cur.s + 1) && (cyc <= cur.s + int'(PW));
         m_cnt = n_push - n_start;
         chk("sel", int'(sel), int'(last_sel));
         chk("din", int'(din), int'(m_din));
         chk("count", int'(count), m_cnt);
         chk("in_ready", int'(in_ready), int'(m_cnt != int'(DEPTH)));
         chk("busy", int'(busy), int'(have_cur || m_cnt != 0));
      end
   end

   initial begin
      bit         acc;
      int         got;
      int         guard;
      logic [1:0] d;

      model_clear();
      // reset with random inputs
      rst_n = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         in_valid = 1'($urandom_range(0, 1));
         in_dest  = 2'($urandom_range(0, 3));
         in_data  = 1'($urandom_range(0, 1));
      end
      chk("rst_sel", int'(sel), 0);
      chk("rst_din", int'(din), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      model_clear();
      chk_en   = 1'b1;

      // single request
      step(1'b1, 2'd2, 1'b1, acc);
      idle(12);

      // back-to-back burst
      for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 1'b1, acc);
      idle(25);

      // overflow: six requests with in_valid held high
      got   = 0;
      guard = 0;
      d     = 2'($urandom_range(0, 3));
      while (got < 6 && guard < 200) begin
         step(1'b1, d, 1'b1, acc);
         if (acc) begin
            got++;
            d = 2'($urandom_range(0, 3));
         end
         guard++;
      end
      chk("overflow_all_accepted", got, 6);
      idle(40);

      // data=0 slot followed by a real strobe
      step(1'b1, 2'd3, 1'b0, acc);
      step(1'b1, 2'd1, 1'b1, acc);
      idle(15);

      // random traffic
      for (int i = 0; i < 80; i++) begin
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), acc);
      end
      idle(45);

      // reset mid-strobe with two requests queued
      step(1'b1, 2'd1, 1'b1, acc);
      step(1'b1, 2'd2, 1'b1, acc);
      step(1'b1, 2'd3, 1'b1, acc);
      in_valid = 1'b0;
      chk("pre_rst_din", int'(din), 1);
      chk("pre_rst_count", int'(count), 2);
      chk_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_din", int'(din), 0);
      chk("midrst_sel", int'(sel), 0);
      chk("midrst_count", int'(count), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      model_clear();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      idle(15);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
